// File: rtl/module_scan_tecladohex_if.sv
// Keypad scanner bus: raw column lines in, row drive and accepted-key codes out.
// The scanner takes the master side; the keypad/decoder side takes the slave side.
interface module_scan_tecladohex_if;
   logic [3:0] col_in;
   logic [3:0] fila_o;
   logic [3:0] fila;
   logic [3:0] col;
   logic       tecla;
   logic       key_held;

   modport master (
      input  col_in,
      output fila_o, fila, col, tecla, key_held
   );

   modport slave (
      output col_in,
      input  fila_o, fila, col, tecla, key_held
   );
endinterface

// File: rtl/module_scan_tecladohex.sv
// Row-scanning, debouncing 4x4 hex keypad controller: one strobe per stable
// single-key press, no auto-repeat, release debounced before scanning resumes.
module module_scan_tecladohex #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 50000
) (
   input logic                      clk,
   input logic                      rst,
   module_scan_tecladohex_if.master kp
);
   localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, HOLD} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    sync1_q, col_s;
   logic [3:0]    row_lat_q, row_lat_d;
   logic [3:0]    col_lat_q, col_lat_d;
   logic [3:0]    fila_o_q, fila_o_d;
   logic [3:0]    fila_q, fila_d;
   logic [3:0]    col_q, col_d;
   logic          tecla_q, tecla_d;
   logic          held_q, held_d;
   logic          onehot_c, last_dwell_c, deb_done_c;
   logic [3:0]    next_row_c;

   // Two-flop synchronizer for the asynchronous column lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 4'b0000;
         col_s   <= 4'b0000;
      end else begin
         sync1_q <= kp.col_in;
         col_s   <= sync1_q;
      end
   end

   assign onehot_c     = (col_s != 4'b0000) && ((col_s & (col_s - 4'd1)) == 4'b0000);
   assign last_dwell_c = (dwell_q == DW'(SCAN_DIV - 1));
   assign deb_done_c   = (cnt_q == CW'(DEBOUNCE_CNT - 1));
   assign next_row_c   = {fila_o_q[2:0], fila_o_q[3]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SCAN;
         dwell_q   <= '0;
         cnt_q     <= '0;
         row_lat_q <= 4'b0000;
         col_lat_q <= 4'b0000;
         fila_o_q  <= 4'b0001;
         fila_q    <= 4'b0000;
         col_q     <= 4'b0000;
         tecla_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
         row_lat_q <= row_lat_d;
         col_lat_q <= col_lat_d;
         fila_o_q  <= fila_o_d;
         fila_q    <= fila_d;
         col_q     <= col_d;
         tecla_q   <= tecla_d;
         held_q    <= held_d;
      end
   end

   // Outputs are computed one cycle ahead so they register on the state change
   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      cnt_d     = cnt_q;
      row_lat_d = row_lat_q;
      col_lat_d = col_lat_q;
      fila_o_d  = fila_o_q;
      fila_d    = fila_q;
      col_d     = col_q;
      tecla_d   = 1'b0;
      held_d    = held_q;

      case (state_q)
         SCAN: begin
            if (last_dwell_c) begin
               dwell_d = '0;
               if (onehot_c) begin
                  row_lat_d = fila_o_q;
                  col_lat_d = col_s;
                  cnt_d     = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  fila_o_d = next_row_c;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (col_s == col_lat_q) begin
               if (deb_done_c) begin
                  cnt_d   = '0;
                  fila_d  = row_lat_q;
                  col_d   = col_lat_q;
                  tecla_d = 1'b1;
                  held_d  = 1'b1;
                  state_d = PRESS;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d    = '0;
               dwell_d  = '0;
               fila_o_d = next_row_c;
               state_d  = SCAN;
            end
         end
         PRESS: begin
            cnt_d   = '0;
            state_d = HOLD;
         end
         HOLD: begin
            // Any nonzero column, including a second key, restarts the release count
            if (col_s == 4'b0000) begin
               if (deb_done_c) begin
                  cnt_d    = '0;
                  dwell_d  = '0;
                  fila_o_d = next_row_c;
                  held_d   = 1'b0;
                  state_d  = SCAN;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   assign kp.fila_o   = fila_o_q;
   assign kp.fila     = fila_q;
   assign kp.col      = col_q;
   assign kp.tecla    = tecla_q;
   assign kp.key_held = held_q;
endmodule

// File: tb/tb_module_scan_tecladohex.sv
// Directed plus randomized bench for the keypad scanner, with a keypad model
// driving the columns and an event-level model of accepted presses.
module tb_module_scan_tecladohex;
   localparam int unsigned SD = 4;
   localparam int unsigned DC = 8;

   logic clk;
   logic rst;
   module_scan_tecladohex_if kif ();

   module_scan_tecladohex #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
      .clk(clk),
      .rst(rst),
      .kp (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: up to two keys pressed, plus a raw glitch injector
   logic       ka_on, kb_on;
   logic [1:0] ka_r, ka_c, kb_r, kb_c;
   logic [3:0] glitch;

   always_comb begin
      kif.col_in = glitch;
      if (ka_on && kif.fila_o[ka_r]) kif.col_in = kif.col_in | (4'b0001 << ka_c);
      if (kb_on && kif.fila_o[kb_r]) kif.col_in = kif.col_in | (4'b0001 << kb_c);
   end

   // Every strobe is recorded as {fila, col}
   logic [7:0] strobe_q[$];
   always @(negedge clk) begin
      if (kif.tecla === 1'b1) strobe_q.push_back({kif.fila, kif.col});
   end

   int checks = 0;
   int fails  = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(input int target, input int budget, input string tag);
      int n = 0;
      while (strobe_q.size() < target && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, 32'(strobe_q.size()), 32'(target));
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c);
      ka_r  = r;
      ka_c  = c;
      ka_on = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fila_o"}, 32'(kif.fila_o), 32'h1);
      check({tag, "_fila"}, 32'(kif.fila), 32'h0);
      check({tag, "_col"}, 32'(kif.col), 32'h0);
      check({tag, "_tecla"}, 32'(kif.tecla), 32'h0);
      check({tag, "_key_held"}, 32'(kif.key_held), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         base;
      int         base2;
      logic [3:0] seen;
      logic [3:0] erow;
      logic [1:0] rr, rc;
      logic [7:0] exp_q[$];

      rst = 1'b1; ka_on = 1'b0; kb_on = 1'b0; glitch = 4'b0000;
      ka_r = 2'd0; ka_c = 2'd0; kb_r = 2'd0; kb_c = 2'd0;

      // Reset and idle row rotation, each row held SD cycles
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      check("rot_0", 32'(kif.fila_o), 32'h1);
      for (int k = 1; k < 20; k++) begin
         tick(1);
         erow = 4'b0001 << 2'((k / SD) % 4);
         check($sformatf("rot_%0d", k), 32'(kif.fila_o), 32'(erow));
      end

      // Clean press of key 5 with release timing
      base = strobe_q.size();
      press(2'd1, 2'd1);
      tick(200);
      check("k5_count", 32'(strobe_q.size()), 32'(base + 1));
      check("k5_code", 32'(strobe_q[base]), 32'h22);
      check("k5_held", 32'(kif.key_held), 32'h1);
      ka_on = 1'b0;
      tick(DC + 1);
      check("k5_held_late", 32'(kif.key_held), 32'h1);
      tick(1);
      check("k5_released", 32'(kif.key_held), 32'h0);
      check("k5_resume_row", 32'(kif.fila_o), 32'h4);
      tick(20);

      // Bouncing key 9, then stable
      base = strobe_q.size();
      for (int i = 0; i < 6; i++) begin
         ka_r = 2'd2; ka_c = 2'd2;
         ka_on = (i % 2 == 0);
         tick(2);
      end
      check("k9_bounce_none", 32'(strobe_q.size()), 32'(base));
      press(2'd2, 2'd2);
      wait_strobe(base + 1, 60, "k9_wait");
      tick(20);
      check("k9_count", 32'(strobe_q.size()), 32'(base + 1));
      check("k9_code", 32'(strobe_q[base]), 32'h44);
      ka_on = 1'b0;
      tick(30);

      // Keys 1 and 3 together are rejected, scanning continues
      base = strobe_q.size();
      press(2'd0, 2'd0);
      kb_r = 2'd0; kb_c = 2'd2; kb_on = 1'b1;
      seen = 4'b0000;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         seen = seen | kif.fila_o;
      end
      check("multi_none", 32'(strobe_q.size()), 32'(base));
      check("multi_rotates", 32'(seen), 32'hf);
      ka_on = 1'b0; kb_on = 1'b0;
      tick(10);

      // Key D, release glitch, then repress
      base = strobe_q.size();
      press(2'd3, 2'd3);
      wait_strobe(base + 1, 60, "kd_wait");
      check("kd_code", 32'(strobe_q[base]), 32'h88);
      tick(10);
      ka_on = 1'b0;
      tick(5);
      glitch = 4'b1000;
      tick(1);
      glitch = 4'b0000;
      tick(DC + 1);
      check("kd_glitch_held", 32'(kif.key_held), 32'h1);
      tick(1);
      check("kd_glitch_released", 32'(kif.key_held), 32'h0);
      press(2'd3, 2'd3);
      wait_strobe(base + 2, 60, "kd2_wait");
      check("kd2_code", 32'(strobe_q[base + 1]), 32'h88);
      ka_on = 1'b0;
      tick(30);

      // Asynchronous reset while key 0 is held
      base = strobe_q.size();
      press(2'd3, 2'd1);
      wait_strobe(base + 1, 60, "k0_wait");
      tick(5);
      check("k0_held", 32'(kif.key_held), 32'h1);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      tick(2);
      base2 = strobe_q.size();
      rst = 1'b0;
      wait_strobe(base2 + 1, 60, "k0_rescan_wait");
      check("k0_rescan_code", 32'(strobe_q[base2]), 32'h82);
      tick(20);
      check("k0_no_repeat", 32'(strobe_q.size()), 32'(base2 + 1));
      ka_on = 1'b0;
      tick(30);

      // Random single-key presses against the press-level model
      base = strobe_q.size();
      for (int i = 0; i < 6; i++) begin
         rr = 2'($urandom_range(0, 3));
         rc = 2'($urandom_range(0, 3));
         exp_q.push_back({4'b0001 << rr, 4'b0001 << rc});
         press(rr, rc);
         tick(int'($urandom_range(40, 80)));
         ka_on = 1'b0;
         tick(int'($urandom_range(20, 40)));
      end
      check("rand_count", 32'(strobe_q.size()), 32'(base + 6));
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rand_code_%0d", i), 32'(strobe_q[base + i]), 32'(exp_q[i]));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
